// File: rtl/cfa_window_ctrl_pkg.sv
// Shared constants for the 5x5 CFA window path: window edge, tap index width,
// sequencer FSM encodings and a counter-width helper. The line buffers and the
// gradient unit import this package alongside the window controller.
package cfa_window_ctrl_pkg;

    localparam int unsigned FilterSize     = 5;
    // Bits needed to index one tap along a window edge.
    localparam int unsigned FilterBitWidth = $clog2(FilterSize);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } win_state_e;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cfa_raster_counter.sv
// Column/row raster counter. Holds the coordinates of the next pixel to be
// accepted; the column wraps after Width-1 and bumps the row, and the row wraps
// after Height-1 so the counters end a frame back at (0,0).
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   clr_i  clear both counters (frame arm)
//   inc_i  advance by one pixel
//   col_o  current column
//   row_o  current row
//   eol_o  current column is the last of the row
//   eof_o  current pixel is the last of the frame
module cfa_raster_counter
    import cfa_window_ctrl_pkg::*;
#(
    parameter int unsigned Width  = 64,
    parameter int unsigned Height = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clr_i,
    input  logic                           inc_i,
    output logic [cnt_width(Width)-1:0]    col_o,
    output logic [cnt_width(Height)-1:0]   row_o,
    output logic                           eol_o,
    output logic                           eof_o
);

    localparam int unsigned ColW = cnt_width(Width);
    localparam int unsigned RowW = cnt_width(Height);
    localparam logic [ColW-1:0] LastCol = ColW'(Width - 1);
    localparam logic [RowW-1:0] LastRow = RowW'(Height - 1);

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;

    assign eol_o = (col_q == LastCol);
    assign eof_o = eol_o && (row_q == LastRow);
    assign col_o = col_q;
    assign row_o = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (inc_i) begin
            if (eol_o) begin
                col_d = '0;
                row_d = eof_o ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/cfa_window_ctrl.sv
// Raster sequencer for the 5x5 CFA line-buffer window and gradient stage.
// Accepts one pixel per valid/ready handshake, registers it towards the line
// buffers with a shift enable and a one-hot row-write select, and strobes the
// gradient unit once per pixel that completes a fully populated window.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   frame_start               arms a new frame (ignored unless idle)
//   pix_valid / pix_ready     pixel handshake
//   d_in / d_out              raster pixel in, registered pixel out
//   buf_en                    line-buffer shift enable, one per accepted pixel
//   row_sel                   one-hot line buffer being written
//   win_start                 window-complete strobe to the gradient unit
//   col_cnt / row_cnt         raster position counters
//   busy / frame_done         frame in progress / end-of-frame pulse
module cfa_window_ctrl #(
    parameter int unsigned DataBitWidth = 12,
    parameter int unsigned FilterSize   = cfa_window_ctrl_pkg::FilterSize,
    parameter int unsigned IMG_W        = 64,
    parameter int unsigned IMG_H        = 64
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            frame_start,
    input  logic                                            pix_valid,
    output logic                                            pix_ready,
    input  logic signed [DataBitWidth-1:0]                  d_in,
    output logic signed [DataBitWidth-1:0]                  d_out,
    output logic                                            buf_en,
    output logic [FilterSize-1:0]                           row_sel,
    output logic                                            win_start,
    output logic [cfa_window_ctrl_pkg::cnt_width(IMG_W)-1:0] col_cnt,
    output logic [cfa_window_ctrl_pkg::cnt_width(IMG_H)-1:0] row_cnt,
    output logic                                            busy,
    output logic                                            frame_done
);

    import cfa_window_ctrl_pkg::*;

    localparam int unsigned ColW = cnt_width(IMG_W);
    localparam int unsigned RowW = cnt_width(IMG_H);
    // A window is complete once both counters have reached the window edge.
    localparam logic [ColW-1:0] WinCol      = ColW'(FilterSize - 1);
    localparam logic [RowW-1:0] WinRow      = RowW'(FilterSize - 1);
    localparam logic [RowW-1:0] LastFillRow = RowW'(FilterSize - 2);

    win_state_e state_q, state_d;

    logic                           accept;
    logic                           cnt_clr;
    logic                           eol;
    logic                           eof;
    logic signed [DataBitWidth-1:0] d_out_q, d_out_d;
    logic                           buf_en_q, buf_en_d;
    logic                           win_start_q, win_start_d;
    logic [FilterSize-1:0]          row_sel_q, row_sel_d;

    assign pix_ready  = (state_q == StFill) || (state_q == StRun);
    assign accept     = pix_valid & pix_ready;
    assign cnt_clr    = (state_q == StIdle) && frame_start;
    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);

    assign d_out      = d_out_q;
    assign buf_en     = buf_en_q;
    assign win_start  = win_start_q;
    assign row_sel    = row_sel_q;

    cfa_raster_counter #(
        .Width  (IMG_W),
        .Height (IMG_H)
    ) u_raster_counter (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (cnt_clr),
        .inc_i (accept),
        .col_o (col_cnt),
        .row_o (row_cnt),
        .eol_o (eol),
        .eof_o (eof)
    );

    always_comb begin
        state_d     = state_q;
        d_out_d     = d_out_q;
        row_sel_d   = row_sel_q;
        buf_en_d    = accept;
        // Counters still hold the accepted pixel's coordinates this cycle.
        win_start_d = accept && (row_cnt >= WinRow) && (col_cnt >= WinCol);

        if (accept) begin
            d_out_d = d_in;
        end
        // Advance to the next line buffer only at the end of a row.
        if (accept && eol) begin
            row_sel_d = {row_sel_q[FilterSize-2:0], row_sel_q[FilterSize-1]};
        end

        case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d   = StFill;
                    row_sel_d = FilterSize'(1);
                end
            end
            StFill: begin
                if (accept && eol && (row_cnt == LastFillRow)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept && eof) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            d_out_q     <= '0;
            buf_en_q    <= 1'b0;
            win_start_q <= 1'b0;
            row_sel_q   <= FilterSize'(1);
        end else begin
            state_q     <= state_d;
            d_out_q     <= d_out_d;
            buf_en_q    <= buf_en_d;
            win_start_q <= win_start_d;
            row_sel_q   <= row_sel_d;
        end
    end

endmodule
